// File: rtl/cl_walk_sequencer.sv
// Cache-line walk sequencer: turns one block descriptor into a raster of tag-read beats.
// Optional macro CL_WALK_B2B_EN lets a new descriptor be accepted on the last-beat cycle.
module cl_walk_sequencer #(
  parameter int X_ADDR_WDTH   = 12,
  parameter int Y_ADDR_WDTH   = 12,
  parameter int C_L_H_SIZE    = 3,
  parameter int C_L_V_SIZE    = 3,
  parameter int LUMA_DIM_WDTH = 4,
  parameter int REF_ADDR_WDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              blk_valid,
  output logic                              blk_ready,
  input  logic [X_ADDR_WDTH-1:0]            start_x_in,
  input  logic [Y_ADDR_WDTH-1:0]            start_y_in,
  input  logic [LUMA_DIM_WDTH-1:0]          rf_blk_wdt_in,
  input  logic [LUMA_DIM_WDTH-1:0]          rf_blk_hgt_in,
  input  logic [REF_ADDR_WDTH-1:0]          ref_idx_in,
  input  logic                              tag_compare_stage_ready_d,
  output logic                              set_input_stage_valid,
  output logic [1:0]                        curr_x,
  output logic [1:0]                        curr_y,
  output logic [1:0]                        delta_x,
  output logic [1:0]                        delta_y,
  output logic [X_ADDR_WDTH-C_L_H_SIZE-1:0] curr_x_addr,
  output logic [Y_ADDR_WDTH-C_L_V_SIZE-1:0] curr_y_addr,
  output logic [REF_ADDR_WDTH-1:0]          ref_idx_out,
  output logic                              cur_xy_changed_luma,
  output logic                              last_block_valid_0d,
  output logic                              busy
);

  localparam int XL = X_ADDR_WDTH - C_L_H_SIZE;
  localparam int YL = Y_ADDR_WDTH - C_L_V_SIZE;

  typedef enum logic {IDLE = 1'b0, WALK = 1'b1} state_t;

  state_t          state;
  state_t          next_state;
  logic            rdy_q;
  logic            accept;
  logic            xfer;
  logic            last_beat;
  logic [XL-1:0]   cl_x0;

  logic [X_ADDR_WDTH:0] sum_x;
  logic [Y_ADDR_WDTH:0] sum_y;
  logic [X_ADDR_WDTH:0] pos_x;
  logic [Y_ADDR_WDTH:0] pos_y;

  function automatic logic [1:0] span_x(input logic [X_ADDR_WDTH:0] lo,
                                        input logic [X_ADDR_WDTH:0] hi);
    logic [X_ADDR_WDTH:0] d;
    d = (hi >> C_L_H_SIZE) - (lo >> C_L_H_SIZE);
    return d[1:0];
  endfunction

  function automatic logic [1:0] span_y(input logic [Y_ADDR_WDTH:0] lo,
                                        input logic [Y_ADDR_WDTH:0] hi);
    logic [Y_ADDR_WDTH:0] d;
    d = (hi >> C_L_V_SIZE) - (lo >> C_L_V_SIZE);
    return d[1:0];
  endfunction

  // One extra bit keeps start + size-1 from overflowing before the shift.
  assign pos_x = {1'b0, start_x_in};
  assign pos_y = {1'b0, start_y_in};
  assign sum_x = pos_x + (X_ADDR_WDTH+1)'(rf_blk_wdt_in);
  assign sum_y = pos_y + (Y_ADDR_WDTH+1)'(rf_blk_hgt_in);

  assign last_beat = (curr_x == delta_x) && (curr_y == delta_y);
  assign xfer      = (state == WALK) && tag_compare_stage_ready_d;
  assign accept    = blk_valid && blk_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = WALK;
      WALK: if (xfer && last_beat) next_state = accept ? WALK : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
`ifdef CL_WALK_B2B_EN
    blk_ready = rdy_q || (xfer && last_beat);
`else
    blk_ready = rdy_q;
`endif
    set_input_stage_valid = (state == WALK);
    cur_xy_changed_luma   = (state == WALK);
    busy                  = (state == WALK);
    last_block_valid_0d   = (state == WALK) && last_beat;
  end

  // Idle-ready flag is held low through reset so blk_ready stays 0 until reset clears.
  always_ff @(posedge clk) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= (next_state == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curr_x      <= '0;
      curr_y      <= '0;
      delta_x     <= '0;
      delta_y     <= '0;
      curr_x_addr <= '0;
      curr_y_addr <= '0;
      ref_idx_out <= '0;
    end else if (accept) begin
      cl_x0       <= XL'(pos_x >> C_L_H_SIZE);
      curr_x_addr <= XL'(pos_x >> C_L_H_SIZE);
      curr_y_addr <= YL'(pos_y >> C_L_V_SIZE);
      delta_x     <= span_x(pos_x, sum_x);
      delta_y     <= span_y(pos_y, sum_y);
      curr_x      <= '0;
      curr_y      <= '0;
      ref_idx_out <= ref_idx_in;
    end else if (xfer && !last_beat) begin
      // Address counters wrap freely at the picture edge.
      if (curr_x < delta_x) begin
        curr_x      <= curr_x + 2'd1;
        curr_x_addr <= curr_x_addr + XL'(1);
      end else begin
        curr_x      <= '0;
        curr_x_addr <= cl_x0;
        curr_y      <= curr_y + 2'd1;
        curr_y_addr <= curr_y_addr + YL'(1);
      end
    end
  end

endmodule

// File: tb/tb_cl_walk_sequencer.sv
// Directed bench for cl_walk_sequencer; honours CL_WALK_B2B_EN for the back-to-back case.
module tb_cl_walk_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        blk_valid = 1'b0;
  logic        blk_ready;
  logic [11:0] start_x_in = '0;
  logic [11:0] start_y_in = '0;
  logic [3:0]  rf_blk_wdt_in = '0;
  logic [3:0]  rf_blk_hgt_in = '0;
  logic [3:0]  ref_idx_in = '0;
  logic        tag_compare_stage_ready_d = 1'b1;
  logic        set_input_stage_valid;
  logic [1:0]  curr_x, curr_y, delta_x, delta_y;
  logic [8:0]  curr_x_addr, curr_y_addr;
  logic [3:0]  ref_idx_out;
  logic        cur_xy_changed_luma;
  logic        last_block_valid_0d;
  logic        busy;
  logic [27:0] obs;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  cl_walk_sequencer dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .start_x_in(start_x_in), .start_y_in(start_y_in),
    .rf_blk_wdt_in(rf_blk_wdt_in), .rf_blk_hgt_in(rf_blk_hgt_in),
    .ref_idx_in(ref_idx_in), .tag_compare_stage_ready_d(tag_compare_stage_ready_d),
    .set_input_stage_valid(set_input_stage_valid),
    .curr_x(curr_x), .curr_y(curr_y), .delta_x(delta_x), .delta_y(delta_y),
    .curr_x_addr(curr_x_addr), .curr_y_addr(curr_y_addr), .ref_idx_out(ref_idx_out),
    .cur_xy_changed_luma(cur_xy_changed_luma),
    .last_block_valid_0d(last_block_valid_0d), .busy(busy)
  );

  assign obs = {set_input_stage_valid, curr_x, curr_y, delta_x, delta_y,
                curr_x_addr, curr_y_addr, last_block_valid_0d};

  function automatic logic [27:0] beat(input logic v, input logic [1:0] cx, input logic [1:0] cy,
                                       input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [8:0] xa, input logic [8:0] ya, input logic l);
    return {v, cx, cy, dx, dy, xa, ya, l};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [11:0] sx, input logic [11:0] sy,
                          input logic [3:0] w, input logic [3:0] h, input logic [3:0] r);
    start_x_in = sx; start_y_in = sy; rf_blk_wdt_in = w; rf_blk_hgt_in = h; ref_idx_in = r;
  endtask

  task automatic send(input logic [11:0] sx, input logic [11:0] sy,
                      input logic [3:0] w, input logic [3:0] h, input logic [3:0] r);
    set_desc(sx, sy, w, h, r);
    blk_valid = 1'b1;
    tick;
    blk_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    total++; if (obs !== 28'd0) $display("FAIL reset_beat got=%h exp=%h", obs, 28'd0); else pass_cnt++;
    total++; if (blk_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", blk_ready); else pass_cnt++;
    total++; if ({busy, cur_xy_changed_luma, ref_idx_out} !== 6'd0)
      $display("FAIL reset_misc got=%h exp=0", {busy, cur_xy_changed_luma, ref_idx_out}); else pass_cnt++;
    reset = 1'b0;
    tick;
    total++; if (blk_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", blk_ready); else pass_cnt++;
    total++; if (set_input_stage_valid !== 1'b0) $display("FAIL post_reset_valid got=%b exp=0", set_input_stage_valid); else pass_cnt++;
  endtask

  task automatic test_single;
    send(12'd9, 12'd17, 4'd3, 4'd3, 4'd5);
    total++; if (obs !== beat(1, 0, 0, 0, 0, 9'd1, 9'd2, 1))
      $display("FAIL single_beat got=%h exp=%h", obs, beat(1, 0, 0, 0, 0, 9'd1, 9'd2, 1)); else pass_cnt++;
    total++; if ({ref_idx_out, cur_xy_changed_luma, busy} !== {4'd5, 1'b1, 1'b1})
      $display("FAIL single_ref got=%h exp=%h", {ref_idx_out, cur_xy_changed_luma, busy}, {4'd5, 1'b1, 1'b1}); else pass_cnt++;
    tick;
    total++; if ({set_input_stage_valid, busy, last_block_valid_0d, blk_ready} !== 4'b0001)
      $display("FAIL single_end got=%b exp=0001", {set_input_stage_valid, busy, last_block_valid_0d, blk_ready}); else pass_cnt++;
  endtask

  task automatic test_walk_3x2;
    logic [27:0] exp;
    send(12'd7, 12'd6, 4'd10, 4'd3, 4'd2);
    for (int b = 0; b < 6; b++) begin
      exp = beat(1, 2'(b % 3), 2'(b / 3), 2, 1, 9'(b % 3), 9'(b / 3), b == 5);
      total++; if (obs !== exp) $display("FAIL walk_beat%0d got=%h exp=%h", b, obs, exp); else pass_cnt++;
      tick;
    end
    total++; if ({set_input_stage_valid, busy, blk_ready} !== 3'b001)
      $display("FAIL walk_end got=%b exp=001", {set_input_stage_valid, busy, blk_ready}); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [27:0] exp;
    send(12'd7, 12'd6, 4'd10, 4'd3, 4'd3);
    for (int b = 0; b < 6; b++) begin
      exp = beat(1, 2'(b % 3), 2'(b / 3), 2, 1, 9'(b % 3), 9'(b / 3), b == 5);
      if (b == 1 || b == 4) begin
        tag_compare_stage_ready_d = 1'b0;
        for (int s = 0; s < 3; s++) begin
          total++; if (obs !== exp) $display("FAIL bp_hold%0d_%0d got=%h exp=%h", b, s, obs, exp); else pass_cnt++;
          tick;
        end
        tag_compare_stage_ready_d = 1'b1;
      end
      total++; if (obs !== exp) $display("FAIL bp_beat%0d got=%h exp=%h", b, obs, exp); else pass_cnt++;
      tick;
    end
    total++; if (set_input_stage_valid !== 1'b0) $display("FAIL bp_end got=%b exp=0", set_input_stage_valid); else pass_cnt++;
  endtask

  task automatic test_wrap;
    send(12'd4092, 12'd0, 4'd7, 4'd0, 4'd1);
    total++; if (obs !== beat(1, 0, 0, 1, 0, 9'd511, 9'd0, 0))
      $display("FAIL wrap_beat0 got=%h exp=%h", obs, beat(1, 0, 0, 1, 0, 9'd511, 9'd0, 0)); else pass_cnt++;
    tick;
    total++; if (obs !== beat(1, 1, 0, 1, 0, 9'd0, 9'd0, 1))
      $display("FAIL wrap_beat1 got=%h exp=%h", obs, beat(1, 1, 0, 1, 0, 9'd0, 9'd0, 1)); else pass_cnt++;
    tick;
    total++; if (set_input_stage_valid !== 1'b0) $display("FAIL wrap_end got=%b exp=0", set_input_stage_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    set_desc(12'd9, 12'd17, 4'd3, 4'd3, 4'd1);
    blk_valid = 1'b1;
    tick;
    total++; if (obs !== beat(1, 0, 0, 0, 0, 9'd1, 9'd2, 1))
      $display("FAIL b2b_first got=%h exp=%h", obs, beat(1, 0, 0, 0, 0, 9'd1, 9'd2, 1)); else pass_cnt++;
    set_desc(12'd40, 12'd8, 4'd0, 4'd0, 4'd2);
`ifdef CL_WALK_B2B_EN
    total++; if (blk_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", blk_ready); else pass_cnt++;
    tick;
`else
    total++; if (blk_ready !== 1'b0) $display("FAIL b2b_ready got=%b exp=0", blk_ready); else pass_cnt++;
    tick;
    total++; if ({set_input_stage_valid, blk_ready} !== 2'b01)
      $display("FAIL b2b_gap got=%b exp=01", {set_input_stage_valid, blk_ready}); else pass_cnt++;
    tick;
`endif
    blk_valid = 1'b0;
    total++; if (obs !== beat(1, 0, 0, 0, 0, 9'd5, 9'd1, 1))
      $display("FAIL b2b_second got=%h exp=%h", obs, beat(1, 0, 0, 0, 0, 9'd5, 9'd1, 1)); else pass_cnt++;
    total++; if (ref_idx_out !== 4'd2) $display("FAIL b2b_ref got=%0d exp=2", ref_idx_out); else pass_cnt++;
    tick;
    total++; if (set_input_stage_valid !== 1'b0) $display("FAIL b2b_end got=%b exp=0", set_input_stage_valid); else pass_cnt++;
  endtask

  task automatic test_reset_midwalk;
    send(12'd7, 12'd6, 4'd10, 4'd3, 4'd4);
    tick;
    tick;
    total++; if (obs !== beat(1, 2, 0, 2, 1, 9'd2, 9'd0, 0))
      $display("FAIL mid_beat2 got=%h exp=%h", obs, beat(1, 2, 0, 2, 1, 9'd2, 9'd0, 0)); else pass_cnt++;
    reset = 1'b1;
    tick;
    total++; if ({set_input_stage_valid, busy, last_block_valid_0d, blk_ready} !== 4'b0000)
      $display("FAIL mid_abort got=%b exp=0000", {set_input_stage_valid, busy, last_block_valid_0d, blk_ready}); else pass_cnt++;
    reset = 1'b0;
    tick;
    total++; if (blk_ready !== 1'b1) $display("FAIL mid_ready got=%b exp=1", blk_ready); else pass_cnt++;
    send(12'd9, 12'd17, 4'd3, 4'd3, 4'd7);
    total++; if ({obs, ref_idx_out} !== {beat(1, 0, 0, 0, 0, 9'd1, 9'd2, 1), 4'd7})
      $display("FAIL mid_restart got=%h exp=%h", {obs, ref_idx_out}, {beat(1, 0, 0, 0, 0, 9'd1, 9'd2, 1), 4'd7}); else pass_cnt++;
    tick;
    total++; if (set_input_stage_valid !== 1'b0) $display("FAIL mid_restart_end got=%b exp=0", set_input_stage_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_walk_3x2;
    test_backpressure;
    test_wrap;
    test_back_to_back;
    test_reset_midwalk;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
